// File: rtl/packet_mux_pkg.sv
// Shared types and sizing for the packet mux datapath (ingress FIFO + A/B arbiter).
package packet_mux_pkg;
  localparam int DATA_W     = 32;
  localparam int EMPTY_W    = 2;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic {IN_IDLE, IN_PKT} in_state_t;

  typedef struct packed {
    logic               error;
    logic               eop;
    logic               sop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } pkt_word_t;
endpackage

// File: rtl/pkt_ingress_fifo_mem.sv
// Storage for pkt_ingress_fifo: one write port, combinational read of the head entry.
module pkt_fifo_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pkt_ingress_fifo.sv
// Per-port ingress FIFO with SOP/EOP framing policing and FWFT output.
// Define PKT_INGRESS_STORE_FWD_EN to hold packets until their EOP is stored.
module pkt_ingress_fifo
  import packet_mux_pkg::*;
#(
  parameter int DATA_W  = packet_mux_pkg::DATA_W,
  parameter int EMPTY_W = packet_mux_pkg::EMPTY_W,
  parameter int DEPTH   = packet_mux_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic [EMPTY_W-1:0]       in_empty,
  input  logic                     in_error,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [EMPTY_W-1:0]       out_empty,
  output logic                     out_error,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              orphan_cnt,
  output logic [15:0]              framing_err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = DATA_W + EMPTY_W + 3;

  in_state_t      r_state, w_state_nxt;
  logic [AW:0]    r_wr_ptr, r_rd_ptr;
  logic [15:0]    r_orphan_cnt, r_frm_cnt;
  logic           w_full, w_empty, w_push, w_pop;
  logic           w_store, w_orphan, w_frm_err;
  logic [WW-1:0]  w_wword, w_head, w_head_q;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

  // Framing FSM: orphans are accepted but dropped, mid-packet SOPs are flagged.
  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_orphan    = 1'b0;
    w_frm_err   = 1'b0;
    if (w_push) begin
      case (r_state)
        IN_IDLE: begin
          if (in_sop) begin
            w_store = 1'b1;
            if (!in_eop) w_state_nxt = IN_PKT;
          end else begin
            w_orphan = 1'b1;
          end
        end
        IN_PKT: begin
          w_store   = 1'b1;
          w_frm_err = in_sop;
          if (in_eop) w_state_nxt = IN_IDLE;
        end
        default: w_state_nxt = IN_IDLE;
      endcase
    end
  end

  assign w_wword = {in_error | w_frm_err, in_eop, in_sop, in_empty, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IN_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_orphan_cnt <= '0;
      r_frm_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_orphan && r_orphan_cnt != 16'hFFFF) r_orphan_cnt <= r_orphan_cnt + 16'd1;
      if (w_frm_err && r_frm_cnt != 16'hFFFF)   r_frm_cnt    <= r_frm_cnt + 16'd1;
    end
  end

  pkt_fifo_mem #(.W(WW), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_store),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wword),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_head)
  );

`ifdef PKT_INGRESS_STORE_FWD_EN
  logic [AW:0] r_pkt_cnt;
  logic        r_hol_started;
  logic        w_push_eop, w_pop_eop;

  assign w_push_eop = w_store && in_eop;
  assign w_pop_eop  = w_pop && w_head[DATA_W+EMPTY_W+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt     <= '0;
      r_hol_started <= 1'b0;
    end else begin
      if (w_push_eop && !w_pop_eop)      r_pkt_cnt <= r_pkt_cnt + 1'b1;
      else if (!w_push_eop && w_pop_eop) r_pkt_cnt <= r_pkt_cnt - 1'b1;
      if (w_pop) r_hol_started <= !w_pop_eop;
    end
  end

  // Full releases packets longer than the FIFO; once the head has started it must finish.
  assign out_valid = !w_empty && ((r_pkt_cnt != '0) || w_full || r_hol_started);
`else
  assign out_valid = !w_empty;
`endif

  assign w_head_q   = out_valid ? w_head : '0;
  assign out_data   = w_head_q[DATA_W-1:0];
  assign out_empty  = w_head_q[DATA_W +: EMPTY_W];
  assign out_sop    = w_head_q[DATA_W+EMPTY_W];
  assign out_eop    = w_head_q[DATA_W+EMPTY_W+1];
  assign out_error  = w_head_q[DATA_W+EMPTY_W+2];

  assign fill_level      = r_wr_ptr - r_rd_ptr;
  assign orphan_cnt      = r_orphan_cnt;
  assign framing_err_cnt = r_frm_cnt;
endmodule

// File: tb/tb_pkt_ingress_fifo.sv
// Directed self-checking bench for pkt_ingress_fifo (cut-through build; store-forward
// scenarios are added when PKT_INGRESS_STORE_FWD_EN is defined).
module tb_pkt_ingress_fifo;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int D  = 16;

  logic          clk = 0;
  logic          rst_n = 0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 0, in_sop = 0, in_eop = 0, in_error = 0;
  logic [EW-1:0] in_empty = '0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop, out_error;
  logic [EW-1:0] out_empty;
  logic          out_ready = 0;
  logic [4:0]    fill_level;
  logic [15:0]   orphan_cnt, framing_err_cnt;

  int n_run = 0;
  int n_fail = 0;

  pkt_ingress_fifo #(.DATA_W(DW), .EMPTY_W(EW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_error(in_error), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_error(out_error), .out_ready(out_ready),
    .fill_level(fill_level), .orphan_cnt(orphan_cnt), .framing_err_cnt(framing_err_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [DW-1:0] d);
    in_valid = v; in_sop = s; in_eop = e; in_data = d; in_error = 0; in_empty = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(0, 0, 0, '0);
    out_ready = 0;
    cyc(); cyc();
    n_run++;
    if ({out_valid, in_ready, fill_level, orphan_cnt, framing_err_cnt, out_data, out_sop, out_eop, out_error}
        !== {1'b0, 1'b1, 5'd0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b ready=%0b fill=%0d orph=%0d ferr=%0d data=%h, want 0 1 0 0 0 0",
               out_valid, in_ready, fill_level, orphan_cnt, framing_err_cnt, out_data);
    end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_single();
    out_ready = 1;
    drive(1, 1, 1, 32'hA5);
    cyc();
    drive(0, 0, 0, '0);
    n_run++;
    if ({out_valid, out_sop, out_eop, out_error, out_data} !== {4'b1110, 32'hA5}) begin
      n_fail++;
      $display("FAIL single_out: v=%0b s=%0b e=%0b err=%0b data=%h, want 1 1 1 0 a5",
               out_valid, out_sop, out_eop, out_error, out_data);
    end
    cyc();
    n_run++;
    if ({out_valid, fill_level} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL single_drain: valid=%0b fill=%0d, want 0 0", out_valid, fill_level);
    end
  endtask

  task automatic test_fill();
    out_ready = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 0, i == 15, 32'h100 + i);
      cyc();
    end
    drive(0, 0, 0, '0);
    n_run++;
    if ({in_ready, fill_level, out_valid} !== {1'b0, 5'd16, 1'b1}) begin
      n_fail++;
      $display("FAIL full_state: ready=%0b fill=%0d valid=%0b, want 0 16 1", in_ready, fill_level, out_valid);
    end
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      n_run++;
      if ({out_valid, out_data, out_sop, out_eop} !== {1'b1, 32'h100 + i, i == 0, i == 15}) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: v=%0b data=%h s=%0b e=%0b, want 1 %h %0b %0b",
                 i, out_valid, out_data, out_sop, out_eop, 32'h100 + i, i == 0, i == 15);
      end
      if (i == 0) begin
        cyc();
        n_run++;
        if ({in_ready, fill_level} !== {1'b1, 5'd15}) begin
          n_fail++;
          $display("FAIL ready_after_pop: ready=%0b fill=%0d, want 1 15", in_ready, fill_level);
        end
      end else begin
        cyc();
      end
    end
    n_run++;
    if ({out_valid, fill_level} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL fill_drain: valid=%0b fill=%0d, want 0 0", out_valid, fill_level);
    end
  endtask

  task automatic test_orphan();
    logic [DW-1:0] pd [3];
    pd[0] = 32'h10; pd[1] = 32'h11; pd[2] = 32'h12;
    out_ready = 1;
    drive(1, 0, 1, 32'h77);
    cyc();
    drive(0, 0, 0, '0);
    n_run++;
    if ({out_valid, fill_level, orphan_cnt} !== {1'b0, 5'd0, 16'd1}) begin
      n_fail++;
      $display("FAIL orphan_drop: valid=%0b fill=%0d orph=%0d, want 0 0 1", out_valid, fill_level, orphan_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 0, i == 2, pd[i]);
      cyc();
      n_run++;
      if ({out_valid, out_data, out_sop, out_eop, out_error} !== {1'b1, pd[i], i == 0, i == 2, 1'b0}) begin
        n_fail++;
        $display("FAIL orphan_pkt[%0d]: v=%0b data=%h s=%0b e=%0b err=%0b, want 1 %h %0b %0b 0",
                 i, out_valid, out_data, out_sop, out_eop, out_error, pd[i], i == 0, i == 2);
      end
    end
    drive(0, 0, 0, '0);
    cyc();
    n_run++;
    if ({out_valid, orphan_cnt} !== {1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL orphan_after: valid=%0b orph=%0d, want 0 1", out_valid, orphan_cnt);
    end
  endtask

  task automatic test_framing();
    logic [3:0] sops, eops, errs;
    sops = 4'b0101; eops = 4'b1000; errs = 4'b0100;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, sops[i], eops[i], 32'h20 + i);
      cyc();
    end
    drive(0, 0, 0, '0);
    n_run++;
    if ({framing_err_cnt, fill_level} !== {16'd1, 5'd4}) begin
      n_fail++;
      $display("FAIL framing_cnt: ferr=%0d fill=%0d, want 1 4", framing_err_cnt, fill_level);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if ({out_valid, out_data, out_sop, out_error} !== {1'b1, 32'h20 + i, sops[i], errs[i]}) begin
        n_fail++;
        $display("FAIL framing_out[%0d]: v=%0b data=%h s=%0b err=%0b, want 1 %h %0b %0b",
                 i, out_valid, out_data, out_sop, out_error, 32'h20 + i, sops[i], errs[i]);
      end
      cyc();
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, i == 0, 0, 32'h300 + i);
      cyc();
    end
    drive(0, 0, 0, '0);
    #2 rst_n = 0;
    #1;
    n_run++;
    if ({out_valid, in_ready, fill_level, orphan_cnt, framing_err_cnt, out_data}
        !== {1'b0, 1'b1, 5'd0, 16'd0, 16'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset: v=%0b ready=%0b fill=%0d orph=%0d ferr=%0d data=%h, want 0 1 0 0 0 0",
               out_valid, in_ready, fill_level, orphan_cnt, framing_err_cnt, out_data);
    end
    cyc();
    rst_n = 1;
    cyc();
    out_ready = 1;
    drive(1, 1, 1, 32'h5A);
    cyc();
    drive(0, 0, 0, '0);
    n_run++;
    if ({out_valid, out_data, out_sop, out_eop, out_error, framing_err_cnt} !== {1'b1, 32'h5A, 3'b110, 16'd0}) begin
      n_fail++;
      $display("FAIL post_reset_pkt: v=%0b data=%h s=%0b e=%0b err=%0b ferr=%0d, want 1 5a 1 1 0 0",
               out_valid, out_data, out_sop, out_eop, out_error, framing_err_cnt);
    end
    cyc();
  endtask

`ifdef PKT_INGRESS_STORE_FWD_EN
  task automatic test_store_fwd();
    int pushed, popped, budget;
    logic err;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, i == 3, 32'h400 + i);
      cyc();
      drive(0, 0, 0, '0);
      if (i < 3) begin
        n_run++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL sf_hold[%0d]: valid=%0b, want 0", i, out_valid);
        end
        cyc();
      end
    end
    n_run++;
    if ({out_valid, out_sop, out_data} !== {2'b11, 32'h400}) begin
      n_fail++;
      $display("FAIL sf_release: v=%0b s=%0b data=%h, want 1 1 400", out_valid, out_sop, out_data);
    end
    for (int i = 0; i < 4; i++) cyc();
    pushed = 0; popped = 0; budget = 0; err = 0;
    while (popped < 20 && budget < 100) begin
      if (pushed < 20) drive(1, pushed == 0, pushed == 19, 32'h500 + pushed);
      else drive(0, 0, 0, '0);
      if (out_valid && out_data !== 32'h500 + popped) err = 1;
      if (in_valid && in_ready) pushed++;
      if (out_valid && out_ready) popped++;
      cyc();
      budget++;
    end
    drive(0, 0, 0, '0);
    n_run++;
    if (popped != 20 || err) begin
      n_fail++;
      $display("FAIL sf_long_pkt: popped=%0d order_err=%0b, want 20 0", popped, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_orphan();
    test_framing();
    test_mid_reset();
`ifdef PKT_INGRESS_STORE_FWD_EN
    test_store_fwd();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_ingress_fifo.md
# pkt_ingress_fifo

Per-port ingress packet buffer that sits directly upstream of the A/B packet arbiter, one instance per input port. It absorbs output back-pressure while the arbiter is serving the other port. It polices SOP/EOP framing so the arbiter only ever sees well-formed packets, and presents a first-word-fall-through valid/ready stream.

## Interface
Parameters:
- DATA_W, packet_mux_pkg::DATA_W: payload width.
- EMPTY_W, packet_mux_pkg::EMPTY_W: empty-symbol count width.
- DEPTH, packet_mux_pkg::FIFO_DEPTH (16): entries. Must be a power of 2 and ≥ 4.

Ports:
- clk  in  1  sole clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_data / in_valid / in_sop / in_eop / in_empty / in_error  in  DATA_W/1/1/1/EMPTY_W/1  upstream beat.
- in_ready  out  1  FIFO can accept a beat.
- out_data / out_valid / out_sop / out_eop / out_empty / out_error  out  DATA_W/1/1/1/EMPTY_W/1  beat toward the arbiter.
- out_ready  in  1  arbiter accepts the beat.
- fill_level  out  $clog2(DEPTH)+1  stored entries.
- orphan_cnt  out  16  count of discarded orphan beats, saturating.
- framing_err_cnt  out  16  count of SOPs seen mid-packet, saturating.

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Stored word: {error, eop, sop, empty, data}, i.e. DATA_W+EMPTY_W+3 bits.
- Input framing FSM has two states, IN_IDLE and IN_PKT. Both transitions happen on accepted beats only:
  - IN_IDLE, sop && !eop: store, go to IN_PKT.
  - IN_IDLE, sop && eop: store, stay in IN_IDLE.
  - IN_IDLE, !sop: orphan. Accept (in_ready unaffected), do not store, increment orphan_cnt.
  - IN_PKT, !sop: store. Go to IN_IDLE on eop.
  - IN_PKT, sop: store with error forced to 1, increment framing_err_cnt. Treat as a new packet start; go to IN_IDLE if eop is also set, else stay in IN_PKT.
- Counters saturate at 16'hFFFF and are never cleared except by reset.
- in_ready = !full. It is derived from registered state only, with no combinational path from out_ready.
- out_valid = !empty (cut-through mode). out_* show the head entry whenever out_valid is 1. When out_valid is 0, out_* are 0.
- Push and pop in the same cycle: pointers both advance and fill_level is unchanged. When full, in_ready=0, so a same-cycle pop frees space visible the next cycle only.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. full/empty are decoded from the MSB and pointer equality.

## Timing
- Reset values: out_valid=0, out_* data fields 0, in_ready=1, fill_level=0, both counters 0, FSM IN_IDLE, pointers 0. Reset mid-packet discards all contents and any partial packet.
- Latency: a beat pushed on cycle N is presented on out_* in cycle N+1 (registered storage).
- Throughput: one beat per cycle in and out simultaneously.
- out_* are held stable while out_valid && !out_ready.

## Configuration
- PKT_INGRESS_STORE_FWD_EN defined: store-and-forward mode.
  - A stored-EOP counter pkt_cnt (width $clog2(DEPTH)+1) increments on push of an eop word and decrements on pop of an eop word. Both in one cycle leave it unchanged.
  - out_valid = !empty && (pkt_cnt != 0 || full || head-of-line packet already started popping). The full term is the release valve for packets longer than DEPTH, preventing deadlock.
  - Latency becomes EOP push + 1 cycle for the SOP beat.
- Not defined: pure cut-through as specified above; pkt_cnt logic is absent.

## Structure
- packet_mux_pkg gains FIFO_DEPTH (16) and in_state_t (IN_IDLE, IN_PKT). It also gains a pkt_word_t packed struct {error, eop, sop, empty, data} shared with the arbiter environment.
- Sub-module pkt_fifo_mem holds the storage: a simple dual-port register array, one write port, combinational read of the head address. The top level holds pointers, the framing FSM, counters and store-forward gating.

## Test plan
- Single 1-beat packet (sop=eop=1, data=0xA5), out_ready=1 → out_valid at N+1 with data 0xA5 and sop=eop=1; fill_level returns to 0.
- out_ready=0, push 16 beats → in_ready drops after the 16th and fill_level=16. Release out_ready → 16 beats out in order, and in_ready=1 one cycle after the first pop.
- Orphan beat (sop=0) in IN_IDLE → no output, orphan_cnt=1. Then a valid 3-beat packet passes unmodified.
- Packet A sop, data, then sop again mid-packet → framing_err_cnt=1 and the second SOP beat emerges with error=1.
- With PKT_INGRESS_STORE_FWD_EN, 4-beat packet pushed at 1 beat per 2 cycles → out_valid stays 0 until the cycle after EOP push. A 20-beat packet releases when full with no deadlock.
- Assert rst_n low while 5 entries are stored and the FSM is in IN_PKT → all outputs at reset values asynchronously. The next packet after release is forwarded correctly.
